// File: rtl/serial_pkg.sv
// Shared definitions for the serial pattern transmitter and the sequence
// detector blocks it drives, so both sides agree on the idle line level.
package serial_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Line level between transmissions; detectors hold their start state on it.
   localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/load_down_counter.sv
// Loadable down-counter with a terminal-count (zero) flag.
// Load wins over enable; the count stops at zero rather than wrapping.
module load_down_counter #(
   parameter int W = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         enable,
   output logic         zero
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] count;

   // Count register: load, otherwise decrement toward zero when enabled.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable && (count != '0)) begin
         count <= count - ONE;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a captured WIDTH-bit pattern out
// MSB-first, optionally repeating it with idle-level gaps between copies.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | line at idle level, waiting for start
// S_SEND | shifting one pattern bit per cycle onto serial_out
// S_GAP  | idle-level cycles between two copies
// S_DONE | single-cycle done pulse, then back to S_IDLE
module serial_pattern_tx
   import serial_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] pattern,
   input  logic [CNT_W-1:0] repeats,
   input  logic [CNT_W-1:0] gap,
   output logic             serial_out,
   output logic             bit_valid,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] sent_count
);

   localparam int              BIT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [WIDTH-1:0]   pat_q, pat_d;
   logic [CNT_W-1:0]   copies_q, copies_d;
   logic [CNT_W-1:0]   gap_q, gap_d;
   logic [CNT_W-1:0]   sent_q, sent_d;
   logic [CNT_W-1:0]   gap_reload;
   logic               bit_load, bit_en, bit_zero;
   logic               gap_load, gap_en, gap_zero;
   logic               serial_d, valid_d, busy_d, done_d;

   // Gap counter runs gap-1 down to 0, giving exactly gap idle cycles.
   assign gap_reload = gap_q - CNT_ONE;

   load_down_counter #(.W(BIT_W)) u_bit_cnt (
      .clock      (clock),
      .reset      (reset),
      .load       (bit_load),
      .load_value (BIT_LAST),
      .enable     (bit_en),
      .zero       (bit_zero)
   );

   load_down_counter #(.W(CNT_W)) u_gap_cnt (
      .clock      (clock),
      .reset      (reset),
      .load       (gap_load),
      .load_value (gap_reload),
      .enable     (gap_en),
      .zero       (gap_zero)
   );

   // Next-state, shadow-register and counter-control decode.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      pat_d    = pat_q;
      copies_d = copies_q;
      gap_d    = gap_q;
      sent_d   = sent_q;
      bit_load = 1'b0;
      bit_en   = 1'b0;
      gap_load = 1'b0;
      gap_en   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               pat_d    = pattern;
               shift_d  = pattern;
               copies_d = (repeats == '0) ? CNT_ONE : repeats;
               gap_d    = gap;
               sent_d   = '0;
               bit_load = 1'b1;
               state_d  = S_SEND;
            end
         end
         S_SEND: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               bit_en  = 1'b1;
               shift_d = shift_q << 1;
               if (bit_zero) begin
                  if (sent_q != CNT_MAX) begin
                     sent_d = sent_q + CNT_ONE;
                  end
                  if (copies_q > CNT_ONE) begin
                     copies_d = copies_q - CNT_ONE;
                     shift_d  = pat_q;
                     bit_load = 1'b1;
                     if (gap_q != '0) begin
                        gap_load = 1'b1;
                        state_d  = S_GAP;
                     end
                  end else begin
                     state_d = S_DONE;
                  end
               end
            end
         end
         S_GAP: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (gap_zero) begin
               shift_d  = pat_q;
               bit_load = 1'b1;
               state_d  = S_SEND;
            end else begin
               gap_en = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output values for the coming cycle, decoded from the next state so the
   // registered outputs line up with the state they describe.
   always_comb begin
      serial_d = (state_d == S_SEND) ? shift_d[WIDTH-1] : IDLE_LEVEL;
      valid_d  = (state_d == S_SEND);
      busy_d   = (state_d == S_SEND) || (state_d == S_GAP);
      done_d   = (state_d == S_DONE);
   end

   // State, shadow registers and registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         shift_q    <= '0;
         pat_q      <= '0;
         copies_q   <= '0;
         gap_q      <= '0;
         sent_q     <= '0;
         serial_out <= IDLE_LEVEL;
         bit_valid  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         pat_q      <= pat_d;
         copies_q   <= copies_d;
         gap_q      <= gap_d;
         sent_q     <= sent_d;
         serial_out <= serial_d;
         bit_valid  <= valid_d;
         busy       <= busy_d;
         done       <= done_d;
      end
   end

   assign sent_count = sent_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: 4-bit instance for the main jobs,
// 6-bit instance for a longer pattern on the same clock and reset.
module tb_serial_pattern_tx;

   logic       clock;
   logic       reset;

   logic       start, abort;
   logic [3:0] pattern, repeats, gap;
   logic       serial_out, bit_valid, busy, done;
   logic [3:0] sent_count;

   logic       start6, abort6;
   logic [5:0] pattern6;
   logic [3:0] repeats6, gap6;
   logic       serial_out6, bit_valid6, busy6, done6;
   logic [3:0] sent_count6;

   int n_vec  = 0;
   int n_miss = 0;

   serial_pattern_tx #(.WIDTH(4), .CNT_W(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .pattern    (pattern),
      .repeats    (repeats),
      .gap        (gap),
      .serial_out (serial_out),
      .bit_valid  (bit_valid),
      .busy       (busy),
      .done       (done),
      .sent_count (sent_count)
   );

   serial_pattern_tx #(.WIDTH(6), .CNT_W(4)) dut6 (
      .clock      (clock),
      .reset      (reset),
      .start      (start6),
      .abort      (abort6),
      .pattern    (pattern6),
      .repeats    (repeats6),
      .gap        (gap6),
      .serial_out (serial_out6),
      .bit_valid  (bit_valid6),
      .busy       (busy6),
      .done       (done6),
      .sent_count (sent_count6)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // After this returns we sit 1 time unit past a rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Start a job at the next edge (edge 0), scramble the inputs after capture,
   // then compare cycles 1..n against the hand-written expected streams
   // (ser/val are MSB-first: bit n-1 is cycle 1).
   task automatic run_job(input string name, input logic [3:0] pat, input logic [3:0] rep,
                          input logic [3:0] gp, input int n, input logic [31:0] ser,
                          input logic [31:0] val, input int done_cyc, input logic [3:0] sent);
      pattern = pat;
      repeats = rep;
      gap     = gp;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      pattern = 4'h0;
      repeats = 4'hf;
      gap     = 4'hf;
      for (int c = 1; c <= n; c++) begin
         check($sformatf("%s ser c%0d", name, c), 32'(serial_out), 32'(ser[n-c]));
         check($sformatf("%s valid c%0d", name, c), 32'(bit_valid), 32'(val[n-c]));
         check($sformatf("%s busy c%0d", name, c), 32'(busy), 32'(c < done_cyc));
         check($sformatf("%s done c%0d", name, c), 32'(done), 32'(c == done_cyc));
         if (c >= done_cyc)
            check($sformatf("%s sent c%0d", name, c), 32'(sent_count), 32'(sent));
         tick();
      end
   endtask

   initial begin
      reset    = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      pattern  = 4'h0;
      repeats  = 4'h0;
      gap      = 4'h0;
      start6   = 1'b0;
      abort6   = 1'b0;
      pattern6 = 6'h0;
      repeats6 = 4'h0;
      gap6     = 4'h0;

      // Reset state
      tick();
      tick();
      check("rst serial", 32'(serial_out), 32'(1));
      check("rst valid",  32'(bit_valid),  32'(0));
      check("rst busy",   32'(busy),       32'(0));
      check("rst done",   32'(done),       32'(0));
      check("rst sent",   32'(sent_count), 32'(0));
      reset = 1'b1;
      tick();
      check("idle serial", 32'(serial_out), 32'(1));

      // Single copy, back to back with nothing
      run_job("t1011", 4'b1011, 4'd1, 4'd0, 6, 32'b1011_1_1, 32'b1111_0_0, 5, 4'd1);

      // Three copies with two idle cycles between
      run_job("t0110", 4'b0110, 4'd3, 4'd2, 18,
              32'b0110_11_0110_11_0110_1_1, 32'b1111_00_1111_00_1111_0_0, 17, 4'd3);

      // repeats=0 acts as one copy; gap never used
      run_job("t1000", 4'b1000, 4'd0, 4'd5, 7, 32'b1000_1_1_1, 32'b1111_0_0_0, 5, 4'd1);

      // Two copies, no gap
      run_job("t1101", 4'b1101, 4'd2, 4'd0, 10, 32'b1101_1101_1_1, 32'b1111_1111_0_0, 9, 4'd2);

      // Abort in cycle 6 of a three-copy job, start raised alongside it
      pattern = 4'b1011;
      repeats = 4'd3;
      gap     = 4'd0;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      for (int c = 1; c <= 5; c++) tick();
      check("abort pre ser",  32'(serial_out), 32'(0));
      check("abort pre busy", 32'(busy),       32'(1));
      check("abort pre sent", 32'(sent_count), 32'(1));
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      check("abort ser",   32'(serial_out), 32'(1));
      check("abort busy",  32'(busy),       32'(0));
      check("abort valid", 32'(bit_valid),  32'(0));
      check("abort sent",  32'(sent_count), 32'(1));
      for (int c = 0; c < 8; c++) begin
         check($sformatf("abort nodone %0d", c), 32'(done), 32'(0));
         check($sformatf("abort idle %0d", c), 32'(busy), 32'(0));
         tick();
      end

      // abort blocks start while idle
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("idle abort busy", 32'(busy),       32'(0));
      check("idle abort ser",  32'(serial_out), 32'(1));
      check("idle abort sent", 32'(sent_count), 32'(1));

      // start held high: second job starts the cycle after done
      pattern = 4'b1011;
      repeats = 4'd1;
      gap     = 4'd0;
      start   = 1'b1;
      tick();
      begin
         logic [6:0] ser_h, val_h;
         ser_h = 7'b1011_1_1_1;
         val_h = 7'b1111_0_0_1;
         for (int c = 1; c <= 7; c++) begin
            check($sformatf("hold ser c%0d", c),  32'(serial_out), 32'(ser_h[7-c]));
            check($sformatf("hold busy c%0d", c), 32'(busy),       32'(val_h[7-c]));
            check($sformatf("hold done c%0d", c), 32'(done),       32'(c == 5));
            tick();
         end
      end
      start = 1'b0;
      for (int c = 8; c <= 12; c++) begin
         check($sformatf("hold done c%0d", c), 32'(done), 32'(c == 11));
         tick();
      end

      // Reset during the second copy, two bits in
      pattern = 4'b1011;
      repeats = 4'd2;
      gap     = 4'd0;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      for (int c = 1; c <= 6; c++) tick();
      check("prerst sent", 32'(sent_count), 32'(1));
      check("prerst busy", 32'(busy),       32'(1));
      #2;
      reset = 1'b0;
      #1;
      check("mid rst serial", 32'(serial_out), 32'(1));
      check("mid rst busy",   32'(busy),       32'(0));
      check("mid rst valid",  32'(bit_valid),  32'(0));
      check("mid rst sent",   32'(sent_count), 32'(0));
      #1;
      reset = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         check($sformatf("post rst done %0d", c), 32'(done),       32'(0));
         check($sformatf("post rst ser %0d", c),  32'(serial_out), 32'(1));
      end

      // 6-bit instance: idle high before start, then 001010 MSB first
      for (int c = 0; c < 3; c++) begin
         check($sformatf("w6 idle ser %0d", c), 32'(serial_out6), 32'(1));
         check($sformatf("w6 idle val %0d", c), 32'(bit_valid6),  32'(0));
         tick();
      end
      pattern6 = 6'b001010;
      repeats6 = 4'd1;
      gap6     = 4'd0;
      start6   = 1'b1;
      tick();
      start6   = 1'b0;
      begin
         logic [6:0] ser6;
         ser6 = 7'b001010_1;
         for (int c = 1; c <= 7; c++) begin
            check($sformatf("w6 ser c%0d", c),  32'(serial_out6), 32'(ser6[7-c]));
            check($sformatf("w6 val c%0d", c),  32'(bit_valid6),  32'(c <= 6));
            check($sformatf("w6 done c%0d", c), 32'(done6),       32'(c == 7));
            tick();
         end
      end
      check("w6 sent", 32'(sent_count6), 32'(1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
